cv_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single UART transmit channel between N_REQ byte-stream requesters, e.g. the calculator FSM, an error/status reporter and a ROM banner sender.
- Sits between the requesters and the UART controller's TX_DATA/TX_RDY_T/TX_RDY_R handshake.
- Grants are packet-locked: once granted, a requester keeps the channel until it sends a byte flagged LAST or stalls past a timeout.

---
 rtl/cv_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cv_tx_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART TX channel among N_REQ byte requesters.
// Launch and ACK appear one cycle after VLD&TX_RDY_R; requesters are held off simply by withholding ACK.
module cv_tx_arbiter #(
  parameter int N_REQ     = 3,
  parameter int GUARD_CYC = 4,
  parameter int TIMEOUT   = 48000
) (
  input  logic                 CLK,
  input  logic                 SYS_NRST,
  input  logic [N_REQ-1:0]     REQ_VLD,
  input  logic [8*N_REQ-1:0]   REQ_DATA,
  input  logic [N_REQ-1:0]     REQ_LAST,
  output logic [N_REQ-1:0]     REQ_ACK,
  output logic [N_REQ-1:0]     GNT,
  input  logic                 TX_RDY_R,
  output logic [7:0]           TX_DATA,
  output logic                 TX_RDY_T,
  output logic                 BUSY,
  output logic                 TO_ERR
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int GD_W  = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_TX = 2'd1,
    GUARD   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [GD_W-1:0]   gd_cnt_q, gd_cnt_d;
  logic              eop_q, eop_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [7:0]        txd_q, txd_d;
  logic              stb_q, stb_d;
  logic              busy_q, busy_d;
  logic              toerr_q, toerr_d;

  logic [7:0]        req_byte [N_REQ];
  logic              arb_hit;
  logic [IDX_W-1:0]  arb_idx;
  logic [IDX_W-1:0]  cand;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) req_byte[i] = REQ_DATA[8*i +: 8];
  end

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = wrap_add(ptr_q, off);
      if (REQ_VLD[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    ptr_d    = ptr_q;
    to_cnt_d = to_cnt_q;
    gd_cnt_d = gd_cnt_q;
    eop_d    = eop_q;
    gnt_d    = gnt_q;
    ack_d    = '0;
    txd_d    = txd_q;
    stb_d    = 1'b0;
    busy_d   = busy_q;
    toerr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          gidx_d   = arb_idx;
          gnt_d    = onehot(arb_idx);
          busy_d   = 1'b1;
          to_cnt_d = '0;
          state_d  = WAIT_TX;
        end
      end

      WAIT_TX: begin
        if (REQ_VLD[gidx_q] && TX_RDY_R) begin
          txd_d    = req_byte[gidx_q];
          stb_d    = 1'b1;
          ack_d    = gnt_q;
          eop_d    = REQ_LAST[gidx_q];
          to_cnt_d = '0;
          gd_cnt_d = '0;
          state_d  = GUARD;
        end else if (!REQ_VLD[gidx_q]) begin
          // Only a silent requester is charged; a stalled UART is not its fault.
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            toerr_d  = 1'b1;
            gnt_d    = '0;
            busy_d   = 1'b0;
            ptr_d    = gidx_q;
            to_cnt_d = '0;
            state_d  = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
      end

      GUARD: begin
        if (gd_cnt_q == GD_W'(GUARD_CYC - 1)) begin
          gd_cnt_d = '0;
          if (eop_q) begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            ptr_d   = gidx_q;
            state_d = IDLE;
          end else begin
            state_d = WAIT_TX;
          end
        end else begin
          gd_cnt_d = gd_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!SYS_NRST) begin
      state_q  <= IDLE;
      gidx_q   <= '0;
      ptr_q    <= IDX_W'(N_REQ - 1);
      to_cnt_q <= '0;
      gd_cnt_q <= '0;
      eop_q    <= 1'b0;
      gnt_q    <= '0;
      ack_q    <= '0;
      txd_q    <= 8'h00;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      toerr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      ptr_q    <= ptr_d;
      to_cnt_q <= to_cnt_d;
      gd_cnt_q <= gd_cnt_d;
      eop_q    <= eop_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      txd_q    <= txd_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      toerr_q  <= toerr_d;
    end
  end

  assign REQ_ACK  = ack_q;
  assign GNT      = gnt_q;
  assign TX_DATA  = txd_q;
  assign TX_RDY_T = stb_q;
  assign BUSY     = busy_q;
  assign TO_ERR   = toerr_q;

  a_gnt_onehot:  assert property (@(posedge CLK) disable iff (!SYS_NRST) $onehot0(GNT));
  a_ack_in_gnt:  assert property (@(posedge CLK) disable iff (!SYS_NRST) (REQ_ACK & ~GNT) == '0);
  a_stb_is_ack:  assert property (@(posedge CLK) disable iff (!SYS_NRST) TX_RDY_T == (|REQ_ACK));

endmodule

// File: tb/tb_cv_tx_arbiter.sv
// Bench for cv_tx_arbiter: vector table, directed corner sequences, randomized run vs. a transaction-level model.
module tb_cv_tx_arbiter;

  localparam int NR = 3;
  localparam int GC = 4;
  localparam int TO = 8;

  logic        CLK;
  logic        SYS_NRST;
  logic [2:0]  REQ_VLD;
  logic [23:0] REQ_DATA;
  logic [2:0]  REQ_LAST;
  logic [2:0]  REQ_ACK;
  logic [2:0]  GNT;
  logic        TX_RDY_R;
  logic [7:0]  TX_DATA;
  logic        TX_RDY_T;
  logic        BUSY;
  logic        TO_ERR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  cv_tx_arbiter #(.N_REQ(NR), .GUARD_CYC(GC), .TIMEOUT(TO)) dut (
    .CLK(CLK), .SYS_NRST(SYS_NRST),
    .REQ_VLD(REQ_VLD), .REQ_DATA(REQ_DATA), .REQ_LAST(REQ_LAST),
    .REQ_ACK(REQ_ACK), .GNT(GNT), .TX_RDY_R(TX_RDY_R),
    .TX_DATA(TX_DATA), .TX_RDY_T(TX_RDY_T), .BUSY(BUSY), .TO_ERR(TO_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       nrst;
    logic [2:0] vld;
    logic [2:0] last;
    logic       rdy;
    logic [2:0] e_gnt;
    logic [2:0] e_ack;
    logic       e_stb;
    logic [7:0] e_txd;
    logic       e_busy;
    logic       e_toerr;
  } vec_t;

  vec_t vt[$];

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] g, input logic [2:0] a,
                         input logic s, input logic [7:0] d, input logic b, input logic t);
    chk({nm, "_gnt"},  32'(GNT),      32'(g));
    chk({nm, "_ack"},  32'(REQ_ACK),  32'(a));
    chk({nm, "_stb"},  32'(TX_RDY_T), 32'(s));
    chk({nm, "_txd"},  32'(TX_DATA),  32'(d));
    chk({nm, "_busy"}, 32'(BUSY),     32'(b));
    chk({nm, "_toe"},  32'(TO_ERR),   32'(t));
  endtask

  task automatic do_reset();
    SYS_NRST = 1'b0;
    REQ_VLD  = '0;
    REQ_LAST = '0;
    REQ_DATA = '0;
    TX_RDY_R = 1'b1;
    tick();
    tick();
    SYS_NRST = 1'b1;
  endtask

  function automatic int rr_pick(input int ptr, input logic [2:0] vld);
    int r;
    r = -1;
    for (int off = 1; off <= NR; off++)
      if (r < 0 && vld[(ptr + off) % NR]) r = (ptr + off) % NR;
    return r;
  endfunction

  initial begin
    logic [7:0] ptxd;
    logic [2:0] oh;
    logic [7:0] by;
    int         n_stb;
    int         step0;
    int         t_stb [4];
    logic [7:0] b_stb [4];
    logic [2:0] g_stb [4];
    int         cnt_a;
    int         cnt_b;
    logic       got;
    logic [2:0] m_gnt;
    logic [2:0] e_ack;
    logic       e_stb;
    logic [7:0] m_txd;
    int         m_ptr, m_g, ready_at, end_at;
    int         rem [NR];

    SYS_NRST = 1'b0;
    REQ_VLD  = '0;
    REQ_LAST = '0;
    REQ_DATA = '0;
    TX_RDY_R = 1'b0;

    // Reset with all requesters pending, then six one-byte packets served 0,1,2,0,1,2.
    vt.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0});
    vt.push_back('{1'b0, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0});
    ptxd = 8'h00;
    for (int p = 0; p < 6; p++) begin
      oh = 3'(1 << (p % NR));
      by = 8'(8'h11 * ((p % NR) + 1));
      vt.push_back('{1'b1, 3'b111, 3'b111, 1'b1, oh, 3'b000, 1'b0, ptxd, 1'b1, 1'b0});
      vt.push_back('{1'b1, 3'b111, 3'b111, 1'b1, oh, oh, 1'b1, by, 1'b1, 1'b0});
      for (int k = 0; k < GC - 1; k++)
        vt.push_back('{1'b1, 3'b111, 3'b111, 1'b1, oh, 3'b000, 1'b0, by, 1'b1, 1'b0});
      vt.push_back('{1'b1, 3'b111, 3'b111, 1'b1, 3'b000, 3'b000, 1'b0, by, 1'b0, 1'b0});
      ptxd = by;
    end

    REQ_DATA = 24'h332211;
    for (int k = 0; k < vt.size(); k++) begin
      SYS_NRST = vt[k].nrst;
      REQ_VLD  = vt[k].vld;
      REQ_LAST = vt[k].last;
      TX_RDY_R = vt[k].rdy;
      tick();
      chk_all($sformatf("vec%0d", k), vt[k].e_gnt, vt[k].e_ack, vt[k].e_stb,
              vt[k].e_txd, vt[k].e_busy, vt[k].e_toerr);
    end

    // Three-byte packet from req0 completes before req1 (waiting throughout) gets the channel.
    do_reset();
    REQ_DATA[7:0]  = 8'h31; REQ_LAST[0] = 1'b0; REQ_VLD[0] = 1'b1;
    REQ_DATA[15:8] = 8'h55; REQ_LAST[1] = 1'b1; REQ_VLD[1] = 1'b1;
    n_stb = 0;
    step0 = 0;
    for (int k = 0; k < 4; k++) begin t_stb[k] = 0; b_stb[k] = 8'h00; g_stb[k] = 3'b000; end
    for (int c = 0; c < 80 && n_stb < 4; c++) begin
      tick();
      if (TX_RDY_T) begin
        t_stb[n_stb] = cyc;
        b_stb[n_stb] = TX_DATA;
        g_stb[n_stb] = GNT;
        n_stb++;
      end
      if (REQ_ACK[0]) begin
        step0++;
        if (step0 == 1) REQ_DATA[7:0] = 8'h2B;
        if (step0 == 2) begin REQ_DATA[7:0] = 8'h32; REQ_LAST[0] = 1'b1; end
        if (step0 == 3) REQ_VLD[0] = 1'b0;
      end
      if (REQ_ACK[1]) REQ_VLD[1] = 1'b0;
    end
    chk("pkt_nstb", 32'(n_stb), 32'd4);
    chk("pkt_b0", 32'(b_stb[0]), 32'h31);
    chk("pkt_b1", 32'(b_stb[1]), 32'h2B);
    chk("pkt_b2", 32'(b_stb[2]), 32'h32);
    chk("pkt_b3", 32'(b_stb[3]), 32'h55);
    chk("pkt_g0", 32'(g_stb[0]), 32'b001);
    chk("pkt_g2", 32'(g_stb[2]), 32'b001);
    chk("pkt_g3", 32'(g_stb[3]), 32'b010);
    chk("pkt_sp01", 32'(t_stb[1] - t_stb[0] >= GC + 1), 32'd1);
    chk("pkt_sp12", 32'(t_stb[2] - t_stb[1] >= GC + 1), 32'd1);

    // UART stall with VLD held: no launch and no timeout until TX_RDY_R returns.
    do_reset();
    REQ_DATA[23:16] = 8'h9C; REQ_LAST[2] = 1'b1; REQ_VLD[2] = 1'b1;
    TX_RDY_R = 1'b0;
    tick();
    chk("stall_gnt", 32'(GNT), 32'b100);
    cnt_a = 0;
    cnt_b = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (TX_RDY_T) cnt_a++;
      if (TO_ERR) cnt_b++;
    end
    chk("stall_nstb", 32'(cnt_a), 32'd0);
    chk("stall_ntoe", 32'(cnt_b), 32'd0);
    TX_RDY_R = 1'b1;
    tick();
    chk("stall_stb", 32'(TX_RDY_T), 32'd1);
    chk("stall_txd", 32'(TX_DATA), 32'h9C);
    chk("stall_ack", 32'(REQ_ACK), 32'b100);
    REQ_VLD = '0;

    // Requester withdraws mid-packet: timeout revokes, and the next pick skips the offender.
    do_reset();
    REQ_DATA[15:8] = 8'h77; REQ_LAST[1] = 1'b0; REQ_VLD[1] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = REQ_ACK[1];
    end
    chk("to_ack", 32'(got), 32'd1);
    REQ_VLD = '0;
    cnt_a = 0;
    for (int c = 1; c <= GC + TO - 1; c++) begin
      tick();
      if (TO_ERR) cnt_a++;
    end
    chk("to_early", 32'(cnt_a), 32'd0);
    tick();
    chk("to_pulse", 32'(TO_ERR), 32'd1);
    chk("to_gnt", 32'(GNT), 32'b000);
    chk("to_busy", 32'(BUSY), 32'd0);
    REQ_DATA[23:16] = 8'h88; REQ_LAST = 3'b110; REQ_VLD = 3'b110;
    tick();
    chk("to_next_gnt", 32'(GNT), 32'b100);
    chk("to_one_cyc", 32'(TO_ERR), 32'd0);

    // Reset during GUARD of a two-byte packet aborts it; the second byte waits for re-arbitration.
    do_reset();
    REQ_DATA[7:0] = 8'hA1; REQ_LAST[0] = 1'b0; REQ_VLD[0] = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = REQ_ACK[0];
    end
    chk("rst_ack", 32'(got), 32'd1);
    REQ_DATA[7:0] = 8'hA2; REQ_LAST[0] = 1'b1;
    tick();
    SYS_NRST = 1'b0;
    tick();
    chk_all("rst_mid", 3'b000, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0);
    SYS_NRST = 1'b1;
    tick();
    chk("rst_regnt", 32'(GNT), 32'b001);
    chk("rst_nostb", 32'(TX_RDY_T), 32'd0);
    tick();
    chk("rst_stb", 32'(TX_RDY_T), 32'd1);
    chk("rst_txd", 32'(TX_DATA), 32'hA2);
    REQ_VLD = '0;

    // Randomized traffic against a transaction-level model of grants, launches and packet ends.
    do_reset();
    m_gnt = '0; m_ptr = NR - 1; m_g = 0; ready_at = 0; end_at = -1; m_txd = 8'h00;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    for (int n = 0; n < 600; n++) begin
      tick();
      e_stb = 1'b0;
      e_ack = '0;
      if (m_gnt == '0) begin
        if (REQ_VLD != '0) begin
          m_g      = rr_pick(m_ptr, REQ_VLD);
          m_gnt    = 3'(1 << m_g);
          ready_at = cyc + 1;
        end
      end else if (cyc == end_at) begin
        m_ptr  = m_g;
        m_gnt  = '0;
        end_at = -1;
      end else if (cyc >= ready_at && REQ_VLD[m_g] && TX_RDY_R) begin
        e_stb    = 1'b1;
        e_ack    = m_gnt;
        m_txd    = REQ_DATA[m_g*8 +: 8];
        ready_at = cyc + GC + 1;
        if (REQ_LAST[m_g]) end_at = cyc + GC;
      end
      chk_all("rnd", m_gnt, e_ack, e_stb, m_txd, |m_gnt, 1'b0);
      for (int i = 0; i < NR; i++) begin
        if (e_ack[i]) begin
          rem[i]--;
          if (rem[i] == 0) REQ_VLD[i] = 1'b0;
          else begin
            REQ_DATA[i*8 +: 8] = 8'($urandom);
            REQ_LAST[i]        = (rem[i] == 1);
          end
        end
        if (!REQ_VLD[i] && $urandom_range(0, 3) == 0) begin
          rem[i]             = int'($urandom_range(1, 3));
          REQ_VLD[i]         = 1'b1;
          REQ_DATA[i*8 +: 8] = 8'($urandom);
          REQ_LAST[i]        = (rem[i] == 1);
        end
      end
      TX_RDY_R = ($urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
